// File: rtl/sram_access_arbiter_if.sv
// Bundles the requester, response and SRAM PHY signals of the frame-buffer arbiter.
// Stat outputs exist only when SRAM_ARB_STATS_EN is defined.
interface sram_access_arbiter_if #(
    parameter int PRECISION  = 11,
    parameter int PIXEL_SIZE = 16,
    parameter int ADDR_WIDTH = 20
);
    logic                              frozen;
    logic [2*PRECISION+PIXEL_SIZE-1:0] adc_pixel_data;
    logic                              adc_pixel_ready;
    logic                              adc_pixel_read;
    logic                              spi_active;
    logic                              spi_pixel_valid;
    logic [PIXEL_SIZE-1:0]             spi_pixel_in;
    logic [PRECISION-1:0]              spi_pixel_x;
    logic [PRECISION-1:0]              spi_pixel_y;
    logic                              spi_pixel_ack;
    logic                              request_active;
    logic [PRECISION:0]                request_x;
    logic [PRECISION:0]                request_y;
    logic                              request_ready;
    logic [PIXEL_SIZE-1:0]             request_data;
    logic                              mem_cmd_valid;
    logic                              mem_cmd_write;
    logic [ADDR_WIDTH-1:0]             mem_cmd_addr;
    logic [PIXEL_SIZE-1:0]             mem_cmd_wdata;
    logic [PIXEL_SIZE-1:0]             mem_rdata;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0]                       stat_read_drops;
    logic [15:0]                       stat_adc_discards;
`endif

    // master: the arbiter, which owns the SRAM command bus
    modport master (
        input  frozen, adc_pixel_data, adc_pixel_ready, spi_active, spi_pixel_valid,
        input  spi_pixel_in, spi_pixel_x, spi_pixel_y, request_active, request_x, request_y,
        input  mem_rdata,
`ifdef SRAM_ARB_STATS_EN
        output stat_read_drops, stat_adc_discards,
`endif
        output adc_pixel_read, spi_pixel_ack, request_ready, request_data,
        output mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata
    );

    modport slave (
        output frozen, adc_pixel_data, adc_pixel_ready, spi_active, spi_pixel_valid,
        output spi_pixel_in, spi_pixel_x, spi_pixel_y, request_active, request_x, request_y,
        output mem_rdata,
`ifdef SRAM_ARB_STATS_EN
        input  stat_read_drops, stat_adc_discards,
`endif
        input  adc_pixel_read, spi_pixel_ack, request_ready, request_data,
        input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Single-port frame-buffer SRAM arbiter: foreground reads > SPI writes > ADC writes,
// with write starvation relief and a read-after-write turnaround. Option: SRAM_ARB_STATS_EN.
module sram_access_arbiter #(
    parameter int PRECISION    = 11,
    parameter int PIXEL_SIZE   = 16,
    parameter int ADDR_WIDTH   = 20,
    parameter int FRAME_WIDTH  = 800,
    parameter int FRAME_HEIGHT = 600,
    parameter int READ_LATENCY = 3,
    parameter int STARVE_LIMIT = 4
) (
    input logic                  clk,
    input logic                  rst,
    sram_access_arbiter_if.master bus
);
    localparam int TAG_DEPTH = READ_LATENCY + 1;
    localparam int CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam int SUM_W     = PRECISION + $clog2(FRAME_WIDTH) + 2;
    localparam int FULL_W    = (SUM_W > ADDR_WIDTH) ? SUM_W : ADDR_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_TURN} state_t;

    function automatic logic [ADDR_WIDTH-1:0] lin_addr(input logic [PRECISION-1:0] x,
                                                       input logic [PRECISION-1:0] y);
        logic [FULL_W-1:0] full;
        full = FULL_W'(y) * FULL_W'(FRAME_WIDTH) + FULL_W'(x);
        return full[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic coord_ok(input logic [PRECISION-1:0] x,
                                      input logic [PRECISION-1:0] y);
        return (32'(x) < 32'(FRAME_WIDTH)) && (32'(y) < 32'(FRAME_HEIGHT));
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic [TAG_DEPTH-1:0]   tag_q, tag_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
    logic [PIXEL_SIZE-1:0]  cmd_wdata_q, cmd_wdata_d;
    logic                   request_ready_q, request_ready_d;
    logic [PIXEL_SIZE-1:0]  request_data_q, request_data_d;

    logic [PRECISION-1:0]   adc_x, adc_y;
    logic [PIXEL_SIZE-1:0]  adc_pix;
    logic                   rd_want, spi_elig, adc_elig, wr_elig, adc_discard;
    logic                   spi_ok, adc_ok;
    logic                   grant_rd, grant_spi, grant_adc, drop_rd;

    assign adc_x   = bus.adc_pixel_data[2*PRECISION+PIXEL_SIZE-1 -: PRECISION];
    assign adc_y   = bus.adc_pixel_data[PRECISION+PIXEL_SIZE-1 -: PRECISION];
    assign adc_pix = bus.adc_pixel_data[PIXEL_SIZE-1:0];

    // Out-of-range reads never touch the bus, so they do not compete with writes.
    assign rd_want = bus.request_active & ~bus.request_x[PRECISION] & ~bus.request_y[PRECISION]
                   & coord_ok(bus.request_x[PRECISION-1:0], bus.request_y[PRECISION-1:0]);

    assign spi_elig    = bus.spi_active & bus.spi_pixel_valid;
    assign adc_elig    = bus.adc_pixel_ready & ~bus.frozen & ~bus.spi_active;
    assign wr_elig     = spi_elig | adc_elig;
    assign adc_discard = ~rst & bus.adc_pixel_ready & (bus.frozen | bus.spi_active);
    assign spi_ok      = coord_ok(bus.spi_pixel_x, bus.spi_pixel_y);
    assign adc_ok      = coord_ok(adc_x, adc_y);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        grant_rd     = 1'b0;
        grant_spi    = 1'b0;
        grant_adc    = 1'b0;
        drop_rd      = 1'b0;
        if (rst) begin
            state_d      = ST_IDLE;
            starve_cnt_d = '0;
        end else if (state_q == ST_WRITE && rd_want) begin
            drop_rd = 1'b1;
            state_d = ST_TURN;
        end else if (rd_want && wr_elig && starve_cnt_q == CNT_W'(STARVE_LIMIT)) begin
            drop_rd   = 1'b1;
            grant_spi = spi_elig;
            grant_adc = adc_elig;
        end else if (rd_want) begin
            grant_rd     = 1'b1;
            state_d      = ST_READ;
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else if (wr_elig && state_q != ST_TURN) begin
            grant_spi = spi_elig;
            grant_adc = adc_elig;
        end else begin
            state_d = ST_IDLE;
        end
        // An out-of-range write is consumed without a bus cycle, so no turnaround follows it.
        if (grant_spi || grant_adc) begin
            starve_cnt_d = '0;
            state_d      = ((grant_spi && spi_ok) || (grant_adc && adc_ok)) ? ST_WRITE : ST_IDLE;
        end
        if (!wr_elig) begin
            starve_cnt_d = '0;
        end
    end

    always_comb begin
        cmd_valid_d = grant_rd | (grant_spi & spi_ok) | (grant_adc & adc_ok);
        cmd_write_d = cmd_valid_d & ~grant_rd;
        cmd_addr_d  = '0;
        cmd_wdata_d = '0;
        if (grant_rd) begin
            cmd_addr_d = lin_addr(bus.request_x[PRECISION-1:0], bus.request_y[PRECISION-1:0]);
        end else if (grant_spi && spi_ok) begin
            cmd_addr_d  = lin_addr(bus.spi_pixel_x, bus.spi_pixel_y);
            cmd_wdata_d = bus.spi_pixel_in;
        end else if (grant_adc && adc_ok) begin
            cmd_addr_d  = lin_addr(adc_x, adc_y);
            cmd_wdata_d = adc_pix;
        end
    end

    // Tag pipe: one slot per request cycle, set only when the read really went to the PHY.
    assign tag_d[0] = grant_rd;
    genvar gi;
    generate
        for (gi = 1; gi < TAG_DEPTH; gi++) begin : g_tag
            assign tag_d[gi] = tag_q[gi-1];
        end
    endgenerate

    assign request_ready_d = tag_q[TAG_DEPTH-1];
    assign request_data_d  = tag_q[TAG_DEPTH-1] ? bus.mem_rdata : '0;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] stat_read_drops_q, stat_read_drops_d;
    logic [15:0] stat_adc_discards_q, stat_adc_discards_d;

    always_comb begin
        stat_read_drops_d   = stat_read_drops_q;
        stat_adc_discards_d = stat_adc_discards_q;
        if (drop_rd && stat_read_drops_q != 16'hFFFF) begin
            stat_read_drops_d = stat_read_drops_q + 16'd1;
        end
        if (adc_discard && stat_adc_discards_q != 16'hFFFF) begin
            stat_adc_discards_d = stat_adc_discards_q + 16'd1;
        end
    end

    assign bus.stat_read_drops   = stat_read_drops_q;
    assign bus.stat_adc_discards = stat_adc_discards_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            starve_cnt_q    <= '0;
            tag_q           <= '0;
            cmd_valid_q     <= 1'b0;
            cmd_write_q     <= 1'b0;
            cmd_addr_q      <= '0;
            cmd_wdata_q     <= '0;
            request_ready_q <= 1'b0;
            request_data_q  <= '0;
`ifdef SRAM_ARB_STATS_EN
            stat_read_drops_q   <= '0;
            stat_adc_discards_q <= '0;
`endif
        end else begin
            state_q         <= state_d;
            starve_cnt_q    <= starve_cnt_d;
            tag_q           <= tag_d;
            cmd_valid_q     <= cmd_valid_d;
            cmd_write_q     <= cmd_write_d;
            cmd_addr_q      <= cmd_addr_d;
            cmd_wdata_q     <= cmd_wdata_d;
            request_ready_q <= request_ready_d;
            request_data_q  <= request_data_d;
`ifdef SRAM_ARB_STATS_EN
            stat_read_drops_q   <= stat_read_drops_d;
            stat_adc_discards_q <= stat_adc_discards_d;
`endif
        end
    end

    assign bus.mem_cmd_valid  = cmd_valid_q;
    assign bus.mem_cmd_write  = cmd_write_q;
    assign bus.mem_cmd_addr   = cmd_addr_q;
    assign bus.mem_cmd_wdata  = cmd_wdata_q;
    assign bus.request_ready  = request_ready_q;
    assign bus.request_data   = request_data_q;
    // FWFT pop and SPI ack must land in the grant cycle, so they bypass the output registers.
    assign bus.spi_pixel_ack  = grant_spi;
    assign bus.adc_pixel_read = grant_adc | adc_discard;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: stimulus pushes expected PHY commands and read
// responses into queues; a negedge monitor pops and compares them with cycle stamps.
module tb_sram_access_arbiter;
    localparam int P  = 11;
    localparam int PS = 16;
    localparam int AW = 20;
    localparam int RL = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   pop_cnt = 0;
    int   ack_cnt = 0;

    typedef struct { int cyc; logic wr; logic [AW-1:0] addr; logic [PS-1:0] data; } cmd_exp_t;
    typedef struct { int cyc; logic [PS-1:0] data; } rsp_exp_t;
    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];
    cmd_exp_t ce;
    rsp_exp_t re;
    logic [2*P+PS-1:0] adc_fifo[$];

    logic          pv[RL];
    logic [AW-1:0] pa[RL];

    sram_access_arbiter_if #(.PRECISION(P), .PIXEL_SIZE(PS), .ADDR_WIDTH(AW)) bus();

    sram_access_arbiter #(
        .PRECISION(P), .PIXEL_SIZE(PS), .ADDR_WIDTH(AW), .FRAME_WIDTH(800),
        .FRAME_HEIGHT(600), .READ_LATENCY(RL), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PHY model: data for a read sampled at edge e is presented for sampling at edge e+RL.
    function automatic logic [PS-1:0] phy_data(input logic [AW-1:0] a);
        if (a == 20'd1610) return 16'hA5A5;
        return a[15:0] ^ 16'hC3C3;
    endfunction

    initial for (int i = 0; i < RL; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    always @(posedge clk) begin
        pv[0] <= bus.mem_cmd_valid & ~bus.mem_cmd_write;
        pa[0] <= bus.mem_cmd_addr;
        for (int i = 1; i < RL; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign bus.mem_rdata = pv[RL-1] ? phy_data(pa[RL-1]) : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_cmd_valid === 1'b1) begin
            checks++;
            if (cmd_q.size() == 0) begin
                failures++;
                $display("FAIL cmd_unexpected cyc=%0d actual wr=%0b addr=%0d data=%h required none",
                         cyc, bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_cmd_wdata);
            end else begin
                ce = cmd_q.pop_front();
                if (ce.cyc != cyc || ce.wr !== bus.mem_cmd_write || ce.addr !== bus.mem_cmd_addr ||
                    ce.data !== bus.mem_cmd_wdata) begin
                    failures++;
                    $display("FAIL cmd actual cyc=%0d wr=%0b addr=%0d data=%h required cyc=%0d wr=%0b addr=%0d data=%h",
                             cyc, bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_cmd_wdata,
                             ce.cyc, ce.wr, ce.addr, ce.data);
                end
            end
        end
        if (bus.request_ready === 1'b1) begin
            checks++;
            if (rsp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected cyc=%0d actual data=%h required none", cyc, bus.request_data);
            end else begin
                re = rsp_q.pop_front();
                if (re.cyc != cyc || re.data !== bus.request_data) begin
                    failures++;
                    $display("FAIL rsp actual cyc=%0d data=%h required cyc=%0d data=%h",
                             cyc, bus.request_data, re.cyc, re.data);
                end
            end
        end
        if (bus.adc_pixel_read === 1'b1) pop_cnt++;
        if (bus.spi_pixel_ack === 1'b1) ack_cnt++;
    end

    function automatic logic [2*P+PS-1:0] pix(input int x, input int y, input logic [PS-1:0] d);
        return {P'(x), P'(y), d};
    endfunction

    task automatic adc_refresh();
        bus.adc_pixel_ready = (adc_fifo.size() != 0);
        bus.adc_pixel_data  = (adc_fifo.size() != 0) ? adc_fifo[0] : '0;
    endtask

    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = bus.adc_pixel_read;
        @(posedge clk);
        #1;
        if (pop === 1'b1 && adc_fifo.size() != 0) adc_fifo.delete(0);
        adc_refresh();
    endtask

    task automatic rd(input logic act, input int x, input int y);
        bus.request_active = act;
        bus.request_x      = (P+1)'(x);
        bus.request_y      = (P+1)'(y);
    endtask

    task automatic exp_cmd(input int off, input logic wr, input int a, input logic [PS-1:0] d);
        cmd_exp_t e;
        e.cyc = cyc + off; e.wr = wr; e.addr = AW'(a); e.data = d;
        cmd_q.push_back(e);
    endtask

    task automatic exp_rsp(input int off, input logic [PS-1:0] d);
        rsp_exp_t e;
        e.cyc = cyc + off; e.data = d;
        rsp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rd(1'b0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pop;
        int base_ack;
        rst = 1'b1;
        bus.frozen = 1'b0; bus.spi_active = 1'b0; bus.spi_pixel_valid = 1'b0;
        bus.spi_pixel_in = '0; bus.spi_pixel_x = '0; bus.spi_pixel_y = '0;
        rd(1'b0, 0, 0);
        adc_refresh();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_cmd_valid", 32'(bus.mem_cmd_valid), 0);
        chk("reset_req_ready", 32'(bus.request_ready), 0);
        chk("reset_adc_read", 32'(bus.adc_pixel_read), 0);
        chk("reset_spi_ack", 32'(bus.spi_pixel_ack), 0);
        idle(2);

        // basic read (10,2) -> addr 1610, data A5A5 four cycles later
        rd(1'b1, 10, 2); exp_cmd(1, 1'b0, 1610, 16'h0); exp_rsp(5, 16'hA5A5); tick();
        idle(7);

        // out-of-range reads produce nothing; corner pixel (799,599) reads normally
        rd(1'b1, -1, 5); tick();
        rd(1'b1, 800, 0); tick();
        rd(1'b1, 799, 599); exp_cmd(1, 1'b0, 479999, 16'h0); exp_rsp(5, 16'h913C); tick();
        rd(1'b1, 0, 600); tick();
        idle(7);

        // starvation: 4 reads win, 5th cycle forces ADC write, next read hits turnaround
        base_pop = pop_cnt;
        adc_fifo.push_back(pix(3, 1, 16'h1234)); adc_refresh();
        rd(1'b1, 0, 0); exp_cmd(1, 1'b0, 0, 16'h0); exp_rsp(5, 16'hC3C3); tick();
        rd(1'b1, 1, 0); exp_cmd(1, 1'b0, 1, 16'h0); exp_rsp(5, 16'hC3C2); tick();
        rd(1'b1, 2, 0); exp_cmd(1, 1'b0, 2, 16'h0); exp_rsp(5, 16'hC3C1); tick();
        rd(1'b1, 3, 0); exp_cmd(1, 1'b0, 3, 16'h0); exp_rsp(5, 16'hC3C0); tick();
        rd(1'b1, 4, 0); exp_cmd(1, 1'b1, 803, 16'h1234); tick();
        rd(1'b1, 5, 0); tick();
        rd(1'b1, 6, 0); exp_cmd(1, 1'b0, 6, 16'h0); exp_rsp(5, 16'hC3C5); tick();
        idle(7);
        chk("starve_adc_pops", 32'(pop_cnt - base_pop), 1);
`ifdef SRAM_ARB_STATS_EN
        chk("stat_drops_starve", 32'(bus.stat_read_drops), 2);
`endif

        // write then read: one turnaround cycle drops the read, the following read issues
        base_pop = pop_cnt;
        adc_fifo.push_back(pix(7, 0, 16'hBEEF)); adc_refresh();
        exp_cmd(1, 1'b1, 7, 16'hBEEF); tick();
        rd(1'b1, 8, 0); tick();
        rd(1'b1, 9, 0); exp_cmd(1, 1'b0, 9, 16'h0); exp_rsp(5, 16'hC3CA); tick();
        idle(7);
        chk("turn_adc_pops", 32'(pop_cnt - base_pop), 1);
`ifdef SRAM_ARB_STATS_EN
        chk("stat_drops_turn", 32'(bus.stat_read_drops), 3);
`endif

        // SPI upload: read beats SPI, ADC discarded, out-of-range SPI acked without write
        base_pop = pop_cnt; base_ack = ack_cnt;
        adc_fifo.push_back(pix(1, 1, 16'h1111)); adc_fifo.push_back(pix(2, 1, 16'h2222)); adc_refresh();
        bus.spi_active = 1'b1; bus.spi_pixel_valid = 1'b1;
        bus.spi_pixel_x = 11'd5; bus.spi_pixel_y = 11'd2; bus.spi_pixel_in = 16'hCAFE;
        rd(1'b1, 0, 1); exp_cmd(1, 1'b0, 800, 16'h0); exp_rsp(5, 16'hC0E3); tick();
        rd(1'b0, 0, 0); exp_cmd(1, 1'b1, 1605, 16'hCAFE); tick();
        bus.spi_pixel_x = 11'd800; bus.spi_pixel_y = 11'd0; bus.spi_pixel_in = 16'h1111; tick();
        bus.spi_pixel_valid = 1'b0; tick();
        bus.spi_active = 1'b0;
        idle(6);
        chk("spi_adc_discards", 32'(pop_cnt - base_pop), 2);
        chk("spi_acks", 32'(ack_cnt - base_ack), 2);

        // frozen: five pixels drained with no commands; then out-of-range and valid ADC pixels
        base_pop = pop_cnt;
        bus.frozen = 1'b1;
        for (int i = 0; i < 5; i++) adc_fifo.push_back(pix(1, 1, PS'(i)));
        adc_refresh();
        repeat (7) tick();
        chk("frozen_pops", 32'(pop_cnt - base_pop), 5);
        chk("frozen_fifo_left", 32'(adc_fifo.size()), 0);
`ifdef SRAM_ARB_STATS_EN
        chk("stat_adc_discards", 32'(bus.stat_adc_discards), 7);
`endif
        bus.frozen = 1'b0;
        base_pop = pop_cnt;
        adc_fifo.push_back(pix(0, 600, 16'h7777)); adc_fifo.push_back(pix(2, 0, 16'h4242)); adc_refresh();
        tick();
        exp_cmd(1, 1'b1, 2, 16'h4242); tick();
        idle(3);
        chk("adc_oor_pops", 32'(pop_cnt - base_pop), 2);

        // reset with two reads in flight: no responses afterwards
        rd(1'b1, 1, 0); exp_cmd(1, 1'b0, 1, 16'h0); tick();
        rd(1'b1, 2, 0); exp_cmd(1, 1'b0, 2, 16'h0); tick();
        rd(1'b0, 0, 0); rst = 1'b1; tick();
        chk("rst_cmd_valid", 32'(bus.mem_cmd_valid), 0);
        chk("rst_req_ready", 32'(bus.request_ready), 0);
`ifdef SRAM_ARB_STATS_EN
        chk("rst_stat_drops", 32'(bus.stat_read_drops), 0);
        chk("rst_stat_discards", 32'(bus.stat_adc_discards), 0);
`endif
        tick();
        rst = 1'b0;
        idle(8);

        chk("cmd_queue_left", 32'(cmd_q.size()), 0);
        chk("rsp_queue_left", 32'(rsp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
